mouse_displ_gen: RTL and testbench
==================================

Name: mouse_displ_gen

Overview:
- Decodes the standard 3-byte PS/2 mouse packet stream into per-frame signed 8-bit X/Y displacement and button state.
- Feeds the cursor position accumulator, which adds X_displ/Y_displ once per frame.
- Sits between the PS/2 byte receiver (byte + valid strobe) and the cursor/drawing logic.
- Converts packets arriving at an arbitrary rate into one saturated displacement pair per frame_tick.

Parameters:
- TIMEOUT_CYCLES, 50000: maximum Clk cycles allowed between bytes of one packet before resync (1 ms at 50 MHz).
- INVERT_Y, 1: when 1, Y_displ = -dy (mouse up = screen up, with screen Y increasing downward); when 0, Y_displ = dy.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- rx_byte  in  8  received PS/2 byte
- rx_valid  in  1  one-cycle strobe; rx_byte is valid this cycle
- frame_tick  in  1  one-cycle pulse, once per video frame
- X_displ  out  8  two's-complement X displacement for the current frame
- Y_displ  out  8  two's-complement Y displacement for the current frame
- displ_valid  out  1  one-cycle pulse; X_displ/Y_displ were updated
- btn_left  out  1  left button state from the last good packet
- btn_right  out  1  right button state from the last good packet
- sync_err  out  1  one-cycle pulse on a packet framing error or timeout

Behaviour:
- Reset:
  - All outputs are 0.
  - Accumulators are 0, FSM is in B0, timeout counter is 0.
- FSM states: B0, B1, B2.
  - B0: on rx_valid, check rx_byte[3].
    - If 1: store byte as header, go to B1.
    - If 0: stay in B0 and pulse sync_err.
  - B1: on rx_valid, store X byte, go to B2.
  - B2: on rx_valid, store Y byte, complete the packet, go to B0.
- Timeout:
  - The counter clears on every rx_valid and increments each cycle while in B1 or B2.
  - When it reaches TIMEOUT_CYCLES, go to B0, pulse sync_err and discard the partial packet.
  - The counter is held at 0 in B0.
- Header bit fields: [0] L, [1] R, [3] always 1, [4] X sign, [5] Y sign, [6] X overflow, [7] Y overflow.
- Delta computation:
  - dx = {hdr[4], xbyte} as 9-bit signed; dy = {hdr[5], ybyte} likewise.
  - If the X overflow bit is set, dx = hdr[4] ? -256 : +255. Y overflow is handled the same way for dy.
- On packet completion:
  - btn_left and btn_right update on the next cycle.
  - accX = sat8(accX + dx).
  - accY = sat8(accY + (INVERT_Y ? -dy : dy)).
  - sat8 clamps to [-128, +127]. Compute the sum at 11 bits minimum, then clamp.
- On frame_tick:
  - X_displ/Y_displ take the accumulator values on the next edge, and displ_valid pulses on that same edge.
  - Accumulators clear to 0.
  - Outputs hold until the next frame_tick.
  - A frame with no packets yields 0/0 with displ_valid still pulsed.
- Packet completion and frame_tick in the same cycle:
  - That packet's delta is included in the latched output (saturated).
  - Accumulators clear to 0; nothing is carried into the next frame.
- rx_valid while Reset is high: ignored.
- Reset mid-packet: the partial packet is discarded, and outputs and accumulators return to 0.
- The header byte-3 check is performed only in B0. Bytes in B1/B2 are accepted unconditionally.
- Latency: packet to output is at most one frame (next frame_tick plus 1 Clk).

Test Plan:
- Packet 0x08,0x05,0x03, then frame_tick -> X_displ=0x05, Y_displ=0xFD (-3, INVERT_Y=1), displ_valid pulses once, buttons=0.
- Packets (0x18,0xF6,0x00) and (0x08,0x14,0x00), then tick -> X_displ=0x0A (-10+20); a second tick with no packets -> 0x00/0x00 with displ_valid pulsing.
- Four packets of 0x08,0x50,0x00 (+80 each), then tick -> X_displ=0x7F (saturated); header 0x58 (negative, overflow), then tick -> X_displ=0x80.
- Header byte 0x00 in B0 -> sync_err pulses, FSM stays in B0; following 0x09,0x01,0x01 decodes with btn_left=1, X=+1, Y=0xFF.
- Send 0x08,0x05, then idle TIMEOUT_CYCLES -> sync_err pulses and FSM is in B0; then 0x08,0x02,0x00 plus tick -> X_displ=0x02.
- Third byte and frame_tick in the same cycle (packet +7 in X) -> X_displ=0x07; the next tick with no packets gives 0x00. Assert Reset between bytes 1 and 2 -> all outputs 0, and the next full packet decodes correctly.

Source files
------------

// File: rtl/mouse_displ_gen.sv
// mouse_displ_gen
//   Decodes the 3-byte PS/2 mouse packet stream into one saturated signed
//   X/Y displacement pair per video frame, plus left/right button state.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   rx_byte      received PS/2 byte
//   rx_valid     one-cycle strobe; rx_byte is valid this cycle
//   frame_tick   one-cycle pulse, once per video frame
//   X_displ      two's-complement X displacement for the last frame
//   Y_displ      two's-complement Y displacement for the last frame
//   displ_valid  one-cycle pulse when X_displ/Y_displ were updated
//   btn_left     left button state from the last good packet
//   btn_right    right button state from the last good packet
//   sync_err     one-cycle pulse on a framing error or inter-byte timeout
module mouse_displ_gen #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter bit          INVERT_Y       = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       frame_tick,
    output logic [7:0] X_displ,
    output logic [7:0] Y_displ,
    output logic       displ_valid,
    output logic       btn_left,
    output logic       btn_right,
    output logic       sync_err
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {B0, B1, B2} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    hdr;
    logic [7:0]    xbyte;
    logic [7:0]    acc_x;
    logic [7:0]    acc_y;

    logic               pkt_done;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] add_x;
    logic signed [10:0] add_y;
    logic signed [10:0] sum_x;
    logic signed [10:0] sum_y;
    logic [7:0]         nx;
    logic [7:0]         ny;

    function automatic logic [7:0] sat8(input logic signed [10:0] v);
        if (v > 11'sd127)
            return 8'h7F;
        else if (v < -11'sd128)
            return 8'h80;
        else
            return v[7:0];
    endfunction

    // The Y byte is consumed straight from rx_byte in the completing cycle,
    // so the delta is folded into the accumulators on that same edge.
    always_comb begin
        pkt_done = (state == B2) && rx_valid;

        if (hdr[6])
            dx = hdr[4] ? -11'sd256 : 11'sd255;
        else
            dx = $signed({{3{hdr[4]}}, xbyte});

        if (hdr[7])
            dy = hdr[5] ? -11'sd256 : 11'sd255;
        else
            dy = $signed({{3{hdr[5]}}, rx_byte});

        add_x = pkt_done ? dx : 11'sd0;
        add_y = pkt_done ? (INVERT_Y ? -dy : dy) : 11'sd0;

        sum_x = $signed({{3{acc_x[7]}}, acc_x}) + add_x;
        sum_y = $signed({{3{acc_y[7]}}, acc_y}) + add_y;

        nx = sat8(sum_x);
        ny = sat8(sum_y);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= B0;
            cnt         <= '0;
            hdr         <= '0;
            xbyte       <= '0;
            acc_x       <= '0;
            acc_y       <= '0;
            X_displ     <= '0;
            Y_displ     <= '0;
            displ_valid <= 1'b0;
            btn_left    <= 1'b0;
            btn_right   <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            sync_err    <= 1'b0;
            displ_valid <= 1'b0;

            case (state)
                B0: begin
                    cnt <= '0;
                    if (rx_valid) begin
                        if (rx_byte[3]) begin
                            hdr   <= rx_byte;
                            state <= B1;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                end
                B1, B2: begin
                    if (rx_valid) begin
                        cnt <= '0;
                        if (state == B1) begin
                            xbyte <= rx_byte;
                            state <= B2;
                        end else begin
                            btn_left  <= hdr[0];
                            btn_right <= hdr[1];
                            state     <= B0;
                        end
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        cnt      <= '0;
                        sync_err <= 1'b1;
                        state    <= B0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= B0;
                end
            endcase

            // A packet completing on the tick cycle lands in this frame's output.
            if (frame_tick) begin
                X_displ     <= nx;
                Y_displ     <= ny;
                displ_valid <= 1'b1;
                acc_x       <= '0;
                acc_y       <= '0;
            end else begin
                acc_x <= nx;
                acc_y <= ny;
            end
        end
    end

endmodule

// File: tb/tb_mouse_displ_gen.sv
// tb_mouse_displ_gen
//   Directed self-checking bench for mouse_displ_gen. Inputs are driven on
//   the falling edge and outputs sampled on the falling edge after the
//   active rising edge.
module tb_mouse_displ_gen;

    localparam int unsigned TO = 20;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_tick;
    logic [7:0] X_displ;
    logic [7:0] Y_displ;
    logic       displ_valid;
    logic       btn_left;
    logic       btn_right;
    logic       sync_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] x_seen;
    logic [7:0] y_seen;
    logic       dv_seen;
    logic       se_seen;

    mouse_displ_gen #(
        .TIMEOUT_CYCLES(TO),
        .INVERT_Y(1'b1)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .frame_tick(frame_tick),
        .X_displ(X_displ),
        .Y_displ(Y_displ),
        .displ_valid(displ_valid),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .sync_err(sync_err)
    );

    always #5 Clk = ~Clk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge Clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge Clk);
        rx_valid = 1'b0;
        se_seen  = sync_err;
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] x, input logic [7:0] y);
        send_byte(h);
        send_byte(x);
        send_byte(y);
    endtask

    task automatic tick();
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        x_seen  = X_displ;
        y_seen  = Y_displ;
        dv_seen = displ_valid;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({X_displ, Y_displ} !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_displ: got %h/%h expected 00/00", X_displ, Y_displ);
        end
        n_cmp++;
        if ({displ_valid, btn_left, btn_right, sync_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {displ_valid, btn_left, btn_right, sync_err});
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_basic();
        send_pkt(8'h08, 8'h05, 8'h03);
        tick();
        n_cmp++;
        if (x_seen !== 8'h05) begin
            n_err++;
            $display("FAIL basic_x: got %h expected 05", x_seen);
        end
        n_cmp++;
        if (y_seen !== 8'hFD) begin
            n_err++;
            $display("FAIL basic_y: got %h expected FD", y_seen);
        end
        n_cmp++;
        if (dv_seen !== 1'b1) begin
            n_err++;
            $display("FAIL basic_dv: got %b expected 1", dv_seen);
        end
        @(negedge Clk);
        n_cmp++;
        if (displ_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_dv_once: got %b expected 0", displ_valid);
        end
        n_cmp++;
        if ({btn_left, btn_right} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_btn: got %b expected 00", {btn_left, btn_right});
        end
    endtask

    task automatic test_accumulate();
        send_pkt(8'h18, 8'hF6, 8'h00);
        send_pkt(8'h08, 8'h14, 8'h00);
        tick();
        n_cmp++;
        if ({x_seen, y_seen} !== 16'h0A00) begin
            n_err++;
            $display("FAIL accum_xy: got %h/%h expected 0A/00", x_seen, y_seen);
        end
        tick();
        n_cmp++;
        if ({x_seen, y_seen, dv_seen} !== 17'h0_0001) begin
            n_err++;
            $display("FAIL empty_frame: got %h/%h dv=%b expected 00/00 dv=1",
                     x_seen, y_seen, dv_seen);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) send_pkt(8'h08, 8'h50, 8'h00);
        tick();
        n_cmp++;
        if (x_seen !== 8'h7F) begin
            n_err++;
            $display("FAIL sat_pos: got %h expected 7F", x_seen);
        end
        send_pkt(8'h58, 8'h00, 8'h00);
        tick();
        n_cmp++;
        if ({x_seen, y_seen} !== 16'h8000) begin
            n_err++;
            $display("FAIL sat_neg_ovf: got %h/%h expected 80/00", x_seen, y_seen);
        end
    endtask

    task automatic test_sync_err();
        send_byte(8'h00);
        n_cmp++;
        if (se_seen !== 1'b1) begin
            n_err++;
            $display("FAIL sync_bad_hdr: got %b expected 1", se_seen);
        end
        send_pkt(8'h09, 8'h01, 8'h01);
        n_cmp++;
        if ({btn_left, btn_right} !== 2'b10) begin
            n_err++;
            $display("FAIL sync_btn: got %b expected 10", {btn_left, btn_right});
        end
        tick();
        n_cmp++;
        if ({x_seen, y_seen} !== 16'h01FF) begin
            n_err++;
            $display("FAIL sync_resync_xy: got %h/%h expected 01/FF", x_seen, y_seen);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit hit;
        send_byte(8'h08);
        send_byte(8'h05);
        hit = 1'b0;
        n = 0;
        for (int i = 1; i <= 4 * TO; i++) begin
            @(negedge Clk);
            if (sync_err === 1'b1) begin
                n   = i;
                hit = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!hit || n < TO - 1 || n > TO + 1) begin
            n_err++;
            $display("FAIL timeout_pulse: got pulse=%b after %0d cycles expected pulse=1 after ~%0d",
                     hit, n, TO);
        end
        send_pkt(8'h08, 8'h02, 8'h00);
        tick();
        n_cmp++;
        if ({x_seen, y_seen} !== 16'h0200) begin
            n_err++;
            $display("FAIL timeout_recover: got %h/%h expected 02/00", x_seen, y_seen);
        end
        n_cmp++;
        if (btn_left !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_btn: got %b expected 0", btn_left);
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h08);
        send_byte(8'h07);
        @(negedge Clk);
        rx_byte    = 8'h00;
        rx_valid   = 1'b1;
        frame_tick = 1'b1;
        @(negedge Clk);
        rx_valid   = 1'b0;
        frame_tick = 1'b0;
        n_cmp++;
        if ({X_displ, Y_displ, displ_valid} !== 17'h0E01) begin
            n_err++;
            $display("FAIL same_cycle: got %h/%h dv=%b expected 07/00 dv=1",
                     X_displ, Y_displ, displ_valid);
        end
        tick();
        n_cmp++;
        if ({x_seen, y_seen} !== 16'h0000) begin
            n_err++;
            $display("FAIL same_cycle_no_carry: got %h/%h expected 00/00", x_seen, y_seen);
        end
    endtask

    task automatic test_reset_mid_packet();
        send_pkt(8'h0A, 8'h03, 8'h00);
        tick();
        n_cmp++;
        if ({x_seen, btn_right} !== 9'b0000_0011_1) begin
            n_err++;
            $display("FAIL pre_reset: got x=%h r=%b expected x=03 r=1", x_seen, btn_right);
        end
        send_byte(8'h08);
        @(negedge Clk);
        Reset    = 1'b1;
        rx_byte  = 8'h05;
        rx_valid = 1'b1;
        @(negedge Clk);
        rx_valid = 1'b0;
        Reset    = 1'b0;
        n_cmp++;
        if ({X_displ, Y_displ, displ_valid, btn_left, btn_right, sync_err} !== 20'h0) begin
            n_err++;
            $display("FAIL mid_reset: got %h/%h flags=%b expected 00/00 flags=0000",
                     X_displ, Y_displ, {displ_valid, btn_left, btn_right, sync_err});
        end
        send_pkt(8'h09, 8'h04, 8'h02);
        tick();
        n_cmp++;
        if ({x_seen, y_seen, btn_left} !== 17'b0000_0100_1111_1110_1) begin
            n_err++;
            $display("FAIL post_reset_pkt: got %h/%h l=%b expected 04/FE l=1",
                     x_seen, y_seen, btn_left);
        end
    endtask

    initial begin
        Reset      = 1'b1;
        rx_byte    = 8'h00;
        rx_valid   = 1'b0;
        frame_tick = 1'b0;
        test_reset();
        test_basic();
        test_accumulate();
        test_saturation();
        test_sync_err();
        test_timeout();
        test_back_to_back();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
